// File: rtl/sr_dmem_arbiter.sv
// Data-memory access controller: arbitrates one synchronous word-wide SRAM between the
// CPU load/store path and an external loader port, with lane steering and load formatting.
module sr_dmem_arbiter #(
  parameter int MEM_AW       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_op,
  input  logic              cpu_sign,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [31:0]       ext_wdata,
  input  logic [3:0]        ext_be,
  output logic [31:0]       ext_rdata,
  output logic              ext_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  starveCnt_r;
  logic        ownerExt_r;
  logic        err_r;
  logic        we_r;
  logic        sign_r;
  logic [1:0]  lane_r;
  logic [2:0]  op_r;
  logic        grantCpu_s;
  logic        grantExt_s;
  logic        cpuErr_s;
  logic        unusedBits_s;

  function automatic logic opErr(input logic [2:0] op, input logic [1:0] lane);
    logic e;
    case (op)
      3'b001:  e = 1'b0;
      3'b010:  e = lane[0];
      3'b100:  e = (lane != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] storeBe(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      3'b001:  be = 4'b0001 << lane;
      3'b010:  be = lane[1] ? 4'b1100 : 4'b0011;
      3'b100:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] storeData(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    case (op)
      3'b001:  d = {4{wdata[7:0]}};
      3'b010:  d = {2{wdata[15:0]}};
      3'b100:  d = wdata;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] loadFormat(input logic [2:0] op, input logic [1:0] lane,
                                             input logic sgn, input logic [31:0] raw);
    logic [31:0] sh;
    logic [15:0] h;
    logic [31:0] d;
    sh = raw >> {lane, 3'b000};
    h  = lane[1] ? raw[31:16] : raw[15:0];
    case (op)
      3'b001:  d = {{24{sgn & sh[7]}}, sh[7:0]};
      3'b010:  d = {{16{sgn & h[15]}}, h};
      3'b100:  d = raw;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  assign cpuErr_s     = opErr(cpu_op, cpu_addr[1:0]);
  assign unusedBits_s = ^{cpu_addr[31:MEM_AW+2], ext_addr[31:MEM_AW+2], ext_addr[1:0]};

  // Arbitration: CPU wins contested slots until the external port has starved LIMIT times
  always_comb begin
    grantCpu_s = 1'b0;
    grantExt_s = 1'b0;
    if (cpu_req && ext_req) begin
      if (starveCnt_r == LIMIT) begin
        grantExt_s = 1'b1;
      end else begin
        grantCpu_s = 1'b1;
      end
    end else if (cpu_req) begin
      grantCpu_s = 1'b1;
    end else if (ext_req) begin
      grantExt_s = 1'b1;
    end else begin
      grantCpu_s = 1'b0;
    end
  end

  // Access sequencer: latches the winner, strobes the SRAM once, then pulses ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      starveCnt_r <= 4'd0;
      ownerExt_r  <= 1'b0;
      err_r       <= 1'b0;
      we_r        <= 1'b0;
      sign_r      <= 1'b0;
      lane_r      <= 2'd0;
      op_r        <= 3'd0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'd0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
      cpu_ready   <= 1'b0;
      cpu_err     <= 1'b0;
      ext_ready   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grantCpu_s) begin
            ownerExt_r <= 1'b0;
            err_r      <= cpuErr_s;
            we_r       <= cpu_we;
            sign_r     <= cpu_sign;
            lane_r     <= cpu_addr[1:0];
            op_r       <= cpu_op;
            // An erroneous access never reaches the SRAM
            mem_en     <= ~cpuErr_s;
            mem_we     <= cpu_we & ~cpuErr_s;
            mem_be     <= cpuErr_s ? 4'b0000 : (cpu_we ? storeBe(cpu_op, cpu_addr[1:0]) : 4'b1111);
            mem_addr   <= cpuErr_s ? '0 : cpu_addr[MEM_AW+1:2];
            mem_wdata  <= (cpu_we && !cpuErr_s) ? storeData(cpu_op, cpu_wdata) : 32'd0;
            if (ext_req && (starveCnt_r != LIMIT)) begin
              starveCnt_r <= starveCnt_r + 4'd1;
            end
            state_r    <= ACCESS;
          end else if (grantExt_s) begin
            ownerExt_r  <= 1'b1;
            err_r       <= 1'b0;
            we_r        <= ext_we;
            mem_en      <= 1'b1;
            mem_we      <= ext_we;
            mem_be      <= ext_be;
            mem_addr    <= ext_addr[MEM_AW+1:2];
            mem_wdata   <= ext_wdata;
            starveCnt_r <= 4'd0;
            state_r     <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= 4'd0;
          mem_addr  <= '0;
          mem_wdata <= 32'd0;
          cpu_ready <= ~ownerExt_r;
          cpu_err   <= ~ownerExt_r & err_r;
          ext_ready <= ownerExt_r;
          state_r   <= RESP;
        end
        RESP: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          ext_ready <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Read data is formatted straight from the SRAM output during the response cycle
  always_comb begin
    cpu_rdata = 32'd0;
    ext_rdata = 32'd0;
    if (state_r == RESP) begin
      if (ownerExt_r) begin
        ext_rdata = mem_rdata;
      end else if (!err_r && !we_r) begin
        cpu_rdata = loadFormat(op_r, lane_r, sign_r, mem_rdata);
      end else begin
        cpu_rdata = 32'd0;
      end
    end else begin
      cpu_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_sr_dmem_arbiter.sv
// Randomized self-checking bench for sr_dmem_arbiter with a behavioural SRAM and a
// word-array reference model of memory contents and access rules.
module tb_sr_dmem_arbiter;
  localparam int MEM_AW = 8;
  localparam int LIMIT  = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sign;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_op;
  logic        cpu_ready, cpu_err;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [3:0]  ext_be;
  logic        ext_ready;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checkCnt = 0;
  int errCnt   = 0;

  logic [31:0] sram   [0:255];
  logic [31:0] refMem [0:255];

  sr_dmem_arbiter #(.MEM_AW(MEM_AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_op(cpu_op), .cpu_sign(cpu_sign), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_err(cpu_err), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_rdata(ext_rdata), .ext_ready(ext_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous SRAM with per-byte write enables
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we && mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= sram[mem_addr];
    end
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic expErr(input logic [2:0] op, input logic [1:0] lane);
    return ($countones(op) != 1) || (op == 3'b010 && lane[0]) || (op == 3'b100 && lane != 2'd0);
  endfunction

  function automatic logic [31:0] laneMask(input logic [2:0] op, input logic [1:0] lane);
    if (op == 3'b001) return 32'hFF << (8 * lane);
    else if (op == 3'b010) return 32'hFFFF << (16 * (lane / 2));
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] word, input logic [2:0] op,
                                          input logic [1:0] lane, input logic sgn);
    logic [31:0] v;
    if (op == 3'b001) begin
      v = (word >> (8 * lane)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (op == 3'b010) begin
      v = (word >> (16 * (lane / 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic cpuTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] op, input logic sgn);
    int idx;
    logic [1:0]  lane;
    logic        e;
    logic [31:0] mask, expWd, expRd;
    logic [3:0]  expBe;
    idx   = int'(addr[9:2]);
    lane  = addr[1:0];
    e     = expErr(op, lane);
    mask  = laneMask(op, lane);
    if (op == 3'b001)      expWd = (wdata & 32'hFF) * 32'h0101_0101;
    else if (op == 3'b010) expWd = (wdata & 32'hFFFF) * 32'h0001_0001;
    else                   expWd = wdata;
    for (int b = 0; b < 4; b++) expBe[b] = we ? mask[8*b] : 1'b1;
    expRd = (e || we) ? 32'd0 : expLoad(refMem[idx], op, lane, sgn);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_op = op; cpu_sign = sgn;
    @(posedge clk); #1;
    checkEq("cpu_mem_en", mem_en, !e);
    checkEq("cpu_early_ready", cpu_ready, 1'b0);
    if (!e) begin
      checkEq("cpu_mem_addr", mem_addr, idx);
      checkEq("cpu_mem_we", mem_we, we);
      checkEq("cpu_mem_be", mem_be, expBe);
      if (we) checkEq("cpu_mem_wdata", mem_wdata, expWd);
    end
    cpu_addr = $urandom; cpu_wdata = $urandom; cpu_op = 3'($urandom); cpu_sign = 1'($urandom);
    cpu_we = 1'($urandom);
    @(posedge clk); #1;
    checkEq("cpu_ready", cpu_ready, 1'b1);
    checkEq("cpu_err", cpu_err, e);
    checkEq("cpu_rdata", cpu_rdata, expRd);
    checkEq("cpu_resp_quiet", {mem_en, ext_ready, ext_rdata}, 64'd0);
    if (we && !e) refMem[idx] = (refMem[idx] & ~mask) | (expWd & mask);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    checkEq("cpu_ready_drop", {cpu_ready, cpu_err, cpu_rdata}, 64'd0);
  endtask

  task automatic extTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    int idx;
    logic [31:0] expRd;
    idx   = int'(addr[9:2]);
    expRd = refMem[idx];
    ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata; ext_be = be;
    @(posedge clk); #1;
    checkEq("ext_mem_en", mem_en, 1'b1);
    checkEq("ext_mem_addr", mem_addr, idx);
    checkEq("ext_mem_we", mem_we, we);
    checkEq("ext_mem_be", mem_be, be);
    checkEq("ext_mem_wdata", mem_wdata, wdata);
    ext_addr = $urandom; ext_wdata = $urandom; ext_be = 4'($urandom); ext_we = 1'($urandom);
    @(posedge clk); #1;
    checkEq("ext_ready", ext_ready, 1'b1);
    checkEq("ext_resp_quiet", {mem_en, cpu_ready, cpu_err, cpu_rdata}, 64'd0);
    if (!we) checkEq("ext_rdata", ext_rdata, expRd);
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) refMem[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    ext_req = 1'b0;
    @(posedge clk); #1;
    checkEq("ext_ready_drop", {ext_ready, ext_rdata}, 64'd0);
  endtask

  initial begin
    int grants;
    int cyc;
    int r;
    logic [2:0]  op;
    logic [31:0] a;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_op = 3'd0; cpu_sign = 1'b0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'd0; ext_wdata = 32'd0; ext_be = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("reset_ctrl", {mem_en, mem_we, mem_be, cpu_ready, cpu_err, ext_ready}, 64'd0);
    checkEq("reset_addr", mem_addr, 64'd0);
    checkEq("reset_data", {mem_wdata, cpu_rdata}, 64'd0);
    checkEq("reset_ext_rdata", ext_rdata, 64'd0);
    rst = 1'b0;

    // Preload every word through the external port
    for (int i = 0; i < 256; i++) extTxn(1'b1, 32'(i * 4), $urandom, 4'hF);

    // Word round trip
    cpuTxn(1'b1, 32'h10, 32'hDEADBEEF, 3'b100, 1'b0);
    cpuTxn(1'b0, 32'h10, 32'h0, 3'b100, 1'b0);

    // Byte/half lanes
    extTxn(1'b1, 32'h20, 32'h80FF7F01, 4'hF);
    cpuTxn(1'b0, 32'h23, 32'h0, 3'b001, 1'b1);
    cpuTxn(1'b0, 32'h23, 32'h0, 3'b001, 1'b0);
    cpuTxn(1'b0, 32'h22, 32'h0, 3'b010, 1'b1);
    cpuTxn(1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
    cpuTxn(1'b1, 32'h21, 32'h000000AB, 3'b001, 1'b0);
    cpuTxn(1'b0, 32'h20, 32'h0, 3'b100, 1'b0);

    // Misalignment and invalid mode, including a store that must not write
    cpuTxn(1'b0, 32'h02, 32'h0, 3'b100, 1'b0);
    cpuTxn(1'b0, 32'h01, 32'h0, 3'b010, 1'b1);
    cpuTxn(1'b0, 32'h00, 32'h0, 3'b011, 1'b0);
    cpuTxn(1'b1, 32'h12, 32'h12345678, 3'b100, 1'b0);
    cpuTxn(1'b0, 32'h10, 32'h0, 3'b100, 1'b0);

    // External byte-enable write and empty write
    extTxn(1'b1, 32'h40, 32'hAAAAAAAA, 4'hF);
    extTxn(1'b1, 32'h40, 32'h11223344, 4'b0101);
    extTxn(1'b0, 32'h40, 32'h0, 4'h0);
    extTxn(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000);
    extTxn(1'b0, 32'h40, 32'h0, 4'h0);

    // Starvation: both requests held, every (LIMIT+1)-th grant goes external
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; cpu_op = 3'b100; cpu_sign = 1'b0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h84; ext_be = 4'hF;
    grants = 0;
    cyc = 0;
    while (grants < 10 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ready || ext_ready) begin
        checkEq("starve_order", {cpu_ready, ext_ready},
                ((grants % (LIMIT + 1)) == LIMIT) ? 64'b01 : 64'b10);
        checkEq("starve_timing", cyc, 2 + 3 * grants);
        if (cpu_ready) checkEq("starve_cpu_rdata", cpu_rdata, refMem[32]);
        else           checkEq("starve_ext_rdata", ext_rdata, refMem[33]);
        grants++;
      end
    end
    cpu_req = 1'b0;
    ext_req = 1'b0;
    checkEq("starve_grants", grants, 10);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a CPU load
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_op = 3'b100; cpu_sign = 1'b0;
    @(posedge clk); #1;
    checkEq("abort_mem_en", mem_en, 1'b1);
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    checkEq("abort_outputs", {mem_en, mem_we, mem_be, mem_addr, cpu_ready, cpu_err, ext_ready}, 64'd0);
    checkEq("abort_data", {mem_wdata, cpu_rdata}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkEq("abort_no_ready", {cpu_ready, cpu_err, cpu_rdata}, 64'd0);
    rst = 1'b1;
    cpu_req = 1'b1;
    @(posedge clk); #1;
    checkEq("rst_no_grant", mem_en, 1'b0);
    rst = 1'b0;
    cpuTxn(1'b0, 32'h10, 32'h0, 3'b100, 1'b0);

    // Randomized mix of CPU and external accesses
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 3)      op = 3'b001;
        else if (r < 6) op = 3'b010;
        else if (r < 9) op = 3'b100;
        else            op = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) a[1:0] = (op == 3'b100) ? 2'b00 : ((op == 3'b010) ? {a[1], 1'b0} : a[1:0]);
        cpuTxn(1'($urandom), a, $urandom, op, 1'($urandom));
      end else begin
        extTxn(1'($urandom), a, $urandom, 4'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/sr_dmem_arbiter.md
# sr_dmem_arbiter

Data-memory access controller for the single-cycle core. It shares one single-port, word-wide synchronous data SRAM between two requesters: the CPU load/store path and an external loader/debug port. The CPU side uses the decoder's byte/half/word one-hot mode and signed-read flag. The block performs lane steering, byte enables, sign/zero extension, misalignment detection and starvation-limited priority arbitration. It stalls the CPU through a request/ready handshake.

## Interface
Parameters:
- MEM_AW, 8, SRAM word-address width (2^MEM_AW words of 32 bits)
- STARVE_LIMIT, 4, consecutive contested CPU grants after which the external port wins one grant (1..15)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_op  in  3  {word, half, byte} one-hot access size
- cpu_sign  in  1  sign-extend loads
- cpu_rdata  out  32  formatted load data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  misaligned/invalid access, valid while cpu_ready
- ext_req  in  1  external request; held until ext_ready
- ext_we  in  1  1 = write
- ext_addr  in  32  byte address; bits [1:0] ignored
- ext_wdata  in  32  write data, lane-aligned
- ext_be  in  4  byte enables
- ext_rdata  out  32  raw memory word, valid while ext_ready
- ext_ready  out  1  one-cycle completion pulse
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write
- mem_be  out  4  SRAM byte enables
- mem_addr  out  MEM_AW  SRAM word address = byte addr[MEM_AW+1:2]; upper bits ignored (wrap)
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

## Operation
- FSM: IDLE, ACCESS, RESP. All mem_* and *_ready/*_err outputs are registered.
- IDLE: no request → stay. Any request → latch owner, address, mode and data; go to ACCESS.
- Arbitration in IDLE: only one request wins directly. With both requests, the CPU wins unless starve_cnt == STARVE_LIMIT; then the external port wins.
- starve_cnt behaviour: +1 when the CPU wins while ext_req=1, saturating at STARVE_LIMIT. Cleared to 0 on any external grant.
- ACCESS: mem_en=1 for exactly one cycle, then RESP. A CPU error access skips the memory: mem_en=0, go directly to RESP.
- RESP: the owner's ready pulses for one cycle, then IDLE. A request still high in the following IDLE cycle is a new request.
- CPU error conditions:
  - cpu_op not exactly one-hot.
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
  - On error: cpu_err=1, cpu_rdata=0, and no memory write occurs.
- CPU store steering, with lane = addr[1:0]:
  - byte: be=1<<lane, wdata={4{wdata[7:0]}}.
  - half: be=0011 (lane 0) or 1100 (lane 2), wdata={2{wdata[15:0]}}.
  - word: be=1111, wdata unchanged.
- CPU load: mem_be=1111, mem_we=0. cpu_rdata is built combinationally in RESP from mem_rdata, using the latched lane.
  - byte lanes 0..3 → bits [8*lane+7:8*lane]; half lanes 0/2 → [15:0]/[31:16].
  - Sign-extended if cpu_sign=1, else zero-extended. Word loads are unchanged.
- External access: mem_be=ext_be, mem_wdata=ext_wdata, and ext_rdata=mem_rdata in RESP.
  - A write with ext_be=0000 still occupies the slot and writes nothing.
  - External accesses never raise an error.
- The non-owner's ready stays 0. ready and err are 0 outside RESP. cpu_rdata/ext_rdata are 0 outside RESP.

## Timing
- Request high in cycle 0 (IDLE) → mem_en in cycle 1 → ready in cycle 2.
  - Latency is 2 cycles; throughput is one access per 3 cycles.
  - An error access also completes in cycle 2.
- Request fields may change after the grant edge; the latched copies are used.
- Reset values: state IDLE, starve_cnt 0, and every output 0.
- Reset mid-operation: rst sampled high forces IDLE at that edge.
  - No ready pulse for the aborted access.
  - A write already strobed in ACCESS stays committed.
- rst=1 with requests high: no grant that cycle; arbitration resumes on the first edge with rst=0.
- Simultaneous requests in IDLE: exactly one grant. The loser is not acknowledged and must keep its request high.

## Test plan
- Word round trip: CPU sw 0xDEADBEEF @0x10, then lw @0x10.
  - Store: mem_en in cycle 1, mem_addr=4, be=1111.
  - Load: cpu_rdata=0xDEADBEEF, cpu_ready in cycle 2 after req.
- Byte/half lanes: with mem word = 0x80FF7F01, check each load:
  - lb @+3 → 0xFFFFFF80; lbu @+3 → 0x00000080.
  - lh @+2 → 0xFFFF80FF; lhu @+0 → 0x00007F01.
  - sb 0xAB @+1 → be=0010, mem_wdata=0xABABABAB.
- Misalignment: lw @0x02, lh @0x01, and cpu_op=011.
  - Each gives cpu_ready+cpu_err in cycle 2, cpu_rdata=0, and no mem_en.
- Starvation (STARVE_LIMIT=4): cpu_req and ext_req held high continuously.
  - Grant order: CPU×4, EXT, CPU×4, EXT.
  - starve_cnt returns to 0 after each EXT grant.
- External write with ext_be=0101, ext_wdata=0x11223344 onto 0xAAAAAAAA, then read back.
  - Readback ext_rdata=0xAA22AA44. A write with be=0000 leaves the word unchanged.
- Reset during ACCESS of a CPU load:
  - No cpu_ready pulse; all outputs 0 the next cycle.
  - A new request after reset completes with normal 2-cycle latency.
